// File: rtl/pseudo_entropy_gen.sv
// Simulation-only fake entropy source: deterministic constant/counter/LFSR words
// offered on a syn/ack handshake with a programmable idle gap and an accept counter.
module pseudo_entropy_gen #(
  parameter int          DATA_WIDTH = 32,
  parameter int          MODE       = 2,
  parameter logic [31:0] SEED       = 32'h00000001,
  parameter int          GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] raw_entropy,
  output logic [31:0]           stats,
  output logic                  enabled,
  output logic                  entropy_syn,
  output logic [DATA_WIDTH-1:0] entropy_data,
  input  logic                  entropy_ack
);

  // An all-zero LFSR would never leave zero, so the LFSR mode starts from 1 instead.
  localparam logic [31:0] SEED_EFF = (MODE == 2 && SEED == 32'd0) ? 32'd1 : SEED;
  localparam bit          NO_GAP   = (GAP_CYCLES == 0);
  localparam logic [7:0]  GAP_LOAD = NO_GAP ? 8'd0 : 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GAP, VALID} state_t;

  state_t      r_state;
  logic [7:0]  r_gap;
  logic [31:0] r_gen;
  logic [31:0] r_stats;
  logic        r_enabled;
  logic        r_syn;
  logic        w_accept;

  function automatic logic [31:0] advance(input logic [31:0] g);
    if (MODE == 1)      return g + 32'd1;
    else if (MODE == 2) return {g[30:0], g[31] ^ g[21] ^ g[1] ^ g[0]};
    else                return g;
  endfunction

  assign w_accept = (r_state == VALID) && entropy_ack;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_gap     <= 8'd0;
      r_gen     <= SEED_EFF;
      r_stats   <= 32'd0;
      r_enabled <= 1'b0;
      r_syn     <= 1'b0;
    end else begin
      // Acceptance is honoured even when enable drops in the same cycle.
      if (w_accept) begin
        r_gen   <= advance(r_gen);
        r_stats <= (r_stats == 32'hFFFF_FFFF) ? r_stats : r_stats + 32'd1;
      end
      if (!enable) begin
        r_state   <= IDLE;
        r_enabled <= 1'b0;
        r_syn     <= 1'b0;
      end else begin
        r_enabled <= 1'b1;
        case (r_state)
          IDLE: begin
            if (NO_GAP) begin
              r_state <= VALID;
              r_syn   <= 1'b1;
            end else begin
              r_state <= GAP;
              r_gap   <= GAP_LOAD;
              r_syn   <= 1'b0;
            end
          end
          GAP: begin
            if (r_gap == 8'd0) begin
              r_state <= VALID;
              r_syn   <= 1'b1;
            end else begin
              r_gap <= r_gap - 8'd1;
            end
          end
          VALID: begin
            if (entropy_ack && !NO_GAP) begin
              r_state <= GAP;
              r_gap   <= GAP_LOAD;
              r_syn   <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_syn   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign enabled      = r_enabled;
  assign entropy_syn  = r_syn;
  assign stats        = r_stats;
  assign raw_entropy  = r_enabled ? r_gen[DATA_WIDTH-1:0] : '0;
  assign entropy_data = r_syn ? r_gen[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_pseudo_entropy_gen.sv
// Bench for pseudo_entropy_gen: four configurations checked every cycle against a
// word-count/ready-time model, plus directed literal expectations.
module tb_pseudo_entropy_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rstn, en, ack;

  logic [31:0] raw0, data0, stats0, raw1, data1, stats1, raw3, data3, stats3, stats2;
  logic [7:0]  raw2, data2;
  logic        en0, en1, en2, en3, syn0, syn1, syn2, syn3;

  // 0: LFSR seed 1 no gap; 1: counter gap 3; 2: 8-bit constant A5 gap 2; 3: LFSR seed 0 gap 1
  pseudo_entropy_gen #(.DATA_WIDTH(32), .MODE(2), .SEED(32'h00000001), .GAP_CYCLES(0)) u0 (
    .clk(clk), .reset_n(rstn[0]), .enable(en[0]), .raw_entropy(raw0), .stats(stats0),
    .enabled(en0), .entropy_syn(syn0), .entropy_data(data0), .entropy_ack(ack[0]));
  pseudo_entropy_gen #(.DATA_WIDTH(32), .MODE(1), .SEED(32'hF1E2D3C4), .GAP_CYCLES(3)) u1 (
    .clk(clk), .reset_n(rstn[1]), .enable(en[1]), .raw_entropy(raw1), .stats(stats1),
    .enabled(en1), .entropy_syn(syn1), .entropy_data(data1), .entropy_ack(ack[1]));
  pseudo_entropy_gen #(.DATA_WIDTH(8), .MODE(0), .SEED(32'h000000A5), .GAP_CYCLES(2)) u2 (
    .clk(clk), .reset_n(rstn[2]), .enable(en[2]), .raw_entropy(raw2), .stats(stats2),
    .enabled(en2), .entropy_syn(syn2), .entropy_data(data2), .entropy_ack(ack[2]));
  pseudo_entropy_gen #(.DATA_WIDTH(32), .MODE(2), .SEED(32'h00000000), .GAP_CYCLES(1)) u3 (
    .clk(clk), .reset_n(rstn[3]), .enable(en[3]), .raw_entropy(raw3), .stats(stats3),
    .enabled(en3), .entropy_syn(syn3), .entropy_data(data3), .entropy_ack(ack[3]));

  function automatic int p_mode(int i);
    case (i) 0: return 2; 1: return 1; 2: return 0; default: return 2; endcase
  endfunction
  function automatic logic [31:0] p_seed(int i);
    case (i) 0: return 32'h1; 1: return 32'hF1E2D3C4; 2: return 32'hA5; default: return 32'h0; endcase
  endfunction
  function automatic int p_gap(int i);
    case (i) 0: return 0; 1: return 3; 2: return 2; default: return 1; endcase
  endfunction
  function automatic logic [31:0] p_mask(int i);
    return (i == 2) ? 32'h000000FF : 32'hFFFFFFFF;
  endfunction

  function automatic logic o_syn(int i);
    case (i) 0: return syn0; 1: return syn1; 2: return syn2; default: return syn3; endcase
  endfunction
  function automatic logic o_en(int i);
    case (i) 0: return en0; 1: return en1; 2: return en2; default: return en3; endcase
  endfunction
  function automatic logic [31:0] o_data(int i);
    case (i) 0: return data0; 1: return data1; 2: return {24'd0, data2}; default: return data3; endcase
  endfunction
  function automatic logic [31:0] o_raw(int i);
    case (i) 0: return raw0; 1: return raw1; 2: return {24'd0, raw2}; default: return raw3; endcase
  endfunction
  function automatic logic [31:0] o_stats(int i);
    case (i) 0: return stats0; 1: return stats1; 2: return stats2; default: return stats3; endcase
  endfunction

  // Model: the generator word is a pure function of the seed and the number of accepted words;
  // a word is on offer when the source is on and the current cycle has reached its ready time.
  int cyc = 0;
  bit armed = 1'b0;
  bit m_on[4];
  int m_ready[4];
  int m_n[4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_on[i] = 1'b0; m_ready[i] = 0; m_n[i] = 0;
    end
  end

  function automatic logic [31:0] gen_at(int i, int n);
    logic [31:0] g;
    g = p_seed(i);
    if (p_mode(i) == 2 && g == 32'd0) g = 32'd1;
    for (int k = 0; k < n; k++) begin
      if (p_mode(i) == 1) g = g + 32'd1;
      else if (p_mode(i) == 2) g = {g[30:0], g[31] ^ g[21] ^ g[1] ^ g[0]};
    end
    return g;
  endfunction

  function automatic bit exp_syn(int i, int c);
    return m_on[i] && (c >= m_ready[i]);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn == 4'h0) armed <= 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!rstn[i]) begin
        m_on[i] <= 1'b0;
        m_n[i]  <= 0;
      end else begin
        if (exp_syn(i, cyc) && ack[i]) m_n[i] <= m_n[i] + 1;
        if (!en[i]) m_on[i] <= 1'b0;
        else if (!m_on[i] || (exp_syn(i, cyc) && ack[i])) begin
          m_on[i]    <= 1'b1;
          m_ready[i] <= cyc + 1 + p_gap(i);
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", name, i, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] g;
    bit s;
    if (!armed) return;
    for (int i = 0; i < 4; i++) begin
      s = exp_syn(i, cyc);
      g = gen_at(i, m_n[i]) & p_mask(i);
      chk("enabled", i, {31'd0, o_en(i)}, {31'd0, m_on[i]});
      chk("syn", i, {31'd0, o_syn(i)}, {31'd0, s});
      chk("data", i, o_data(i), s ? g : 32'd0);
      chk("raw", i, o_raw(i), m_on[i] ? g : 32'd0);
      chk("stats", i, o_stats(i), 32'(m_n[i]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_syn(input int i);
    int w;
    w = 0;
    while (!o_syn(i) && w < 50) begin
      tick();
      w++;
    end
    chk("wait_syn_timeout", i, {31'd0, o_syn(i)}, 32'd1);
  endtask

  task automatic measure_gap(input int i, output int low);
    low = 0;
    while (!o_syn(i) && low < 50) begin
      low++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] words[4];
    logic [31:0] exp_lfsr[4];
    int nw, low;
    exp_lfsr[0] = 32'h1; exp_lfsr[1] = 32'h3; exp_lfsr[2] = 32'h6; exp_lfsr[3] = 32'hD;
    rstn = 4'h0; en = 4'h0; ack = 4'h0;

    // Reset then idle
    repeat (2) tick();
    rstn = 4'hF;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      chk("idle_stats", i, o_stats(i), 32'd0);
      chk("idle_syn", i, {31'd0, o_syn(i)}, 32'd0);
    end

    // LFSR back-to-back with ack held high
    en[0] = 1'b1; ack[0] = 1'b1;
    nw = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_syn(0)) begin
        words[nw] = o_data(0);
        nw++;
      end
    end
    chk("lfsr_nwords", 0, 32'(nw), 32'd4);
    for (int k = 0; k < 4; k++) chk("lfsr_word", k, words[k], exp_lfsr[k]);
    tick();
    ack[0] = 1'b0;
    chk("lfsr_stats4", 0, o_stats(0), 32'd4);

    // Backpressure
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_syn", 0, {31'd0, o_syn(0)}, 32'd1);
      chk("bp_data", 0, o_data(0), 32'h1B);
    end
    chk("bp_stats", 0, o_stats(0), 32'd4);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk("bp_stats_after", 0, o_stats(0), 32'd5);
    chk("bp_next_word", 0, o_data(0), 32'h36);

    // Disable and ack together, then re-enable
    ack[0] = 1'b1; en[0] = 1'b0;
    tick();
    ack[0] = 1'b0;
    chk("dis_stats", 0, o_stats(0), 32'd6);
    chk("dis_enabled", 0, {31'd0, o_en(0)}, 32'd0);
    chk("dis_syn", 0, {31'd0, o_syn(0)}, 32'd0);
    repeat (3) tick();
    en[0] = 1'b1;
    wait_syn(0);
    chk("reen_word", 0, o_data(0), 32'h6D);
    en[0] = 1'b0;
    tick();

    // Counter with gap 3
    en[1] = 1'b1;
    tick();
    measure_gap(1, low);
    chk("cnt_first_gap", 1, 32'(low), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("cnt_word", k, o_data(1), 32'hF1E2D3C4 + 32'(k));
      ack[1] = 1'b1;
      tick();
      ack[1] = 1'b0;
      if (k < 2) begin
        measure_gap(1, low);
        chk("cnt_gap", k, 32'(low), 32'd3);
      end
    end
    chk("cnt_stats", 1, o_stats(1), 32'd3);
    en[1] = 1'b0;
    tick();

    // Narrow constant source
    en[2] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_syn(2);
      chk("const_word", k, o_data(2), 32'hA5);
      ack[2] = 1'b1;
      tick();
      ack[2] = 1'b0;
    end
    en[2] = 1'b0;
    tick();

    // Zero seed in LFSR mode, then reset in the middle of a VALID word
    en[3] = 1'b1;
    tick();
    wait_syn(3);
    chk("zseed_first", 3, o_data(3), 32'h1);
    ack[3] = 1'b1;
    tick();
    ack[3] = 1'b0;
    wait_syn(3);
    chk("zseed_second", 3, o_data(3), 32'h3);
    rstn[3] = 1'b0; ack[3] = 1'b1;
    tick();
    chk("rst_syn", 3, {31'd0, o_syn(3)}, 32'd0);
    chk("rst_enabled", 3, {31'd0, o_en(3)}, 32'd0);
    chk("rst_stats", 3, o_stats(3), 32'd0);
    chk("rst_data", 3, o_data(3), 32'd0);
    rstn[3] = 1'b1; ack[3] = 1'b0;
    tick();
    wait_syn(3);
    chk("rst_reseed", 3, o_data(3), 32'h1);
    en[3] = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pseudo_entropy_gen.md
Name: pseudo_entropy_gen

Overview:
- Parametrised, simulation-only fake entropy source for TRNG testbenches. It provides NO real entropy.
- Produces a deterministic, reproducible word stream: constant, counter or 32-bit LFSR.
- Words are offered on a syn/ack handshake with a programmable idle gap between words.
- Stands in for a physical entropy source in front of the entropy mixer. It adds sequencing, flow control and an accepted-word counter on top of the earlier static stub.

Parameters:
- DATA_WIDTH, 32, width of entropy_data and raw_entropy; legal range 8..32; outputs carry gen[DATA_WIDTH-1:0].
- MODE, 2, generator mode: 0 = constant SEED, 1 = incrementing counter, 2 = 32-bit Fibonacci LFSR.
- SEED, 32'h00000001, 32-bit generator reset value. In MODE 2 a SEED of 0 is replaced by 32'h00000001 to avoid lock-up.
- GAP_CYCLES, 0, idle cycles with syn low after each accepted word and after enable; legal range 0..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset (sampled on rising clk).
- enable  in  1  run request.
- raw_entropy  out  DATA_WIDTH  gen[DATA_WIDTH-1:0] while enabled=1, else 0.
- stats  out  32  count of accepted words.
- enabled  out  1  registered; 1 whenever state != IDLE.
- entropy_syn  out  1  word valid; registered, equal to (state == VALID).
- entropy_data  out  DATA_WIDTH  gen[DATA_WIDTH-1:0] while entropy_syn=1, else 0.
- entropy_ack  in  1  consumer accepts the current word.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, gap counter=0, gen=SEED (with the MODE 2 zero fix), stats=0.
  - All outputs 0 from the following cycle. Reset overrides all other inputs, including mid-handshake.
- Generator advance happens only on an accepted word (ack while in VALID), never on other cycles:
  - MODE 0: gen holds.
  - MODE 1: gen <= gen + 1, wrapping 0xFFFFFFFF -> 0.
  - MODE 2: gen <= {gen[30:0], gen[31]^gen[21]^gen[1]^gen[0]}.
- States: IDLE, GAP, VALID.
  - IDLE, enable=1: go to GAP with counter=GAP_CYCLES-1, or directly to VALID if GAP_CYCLES=0.
  - IDLE, enable=0: stay in IDLE.
  - GAP: counter decrements each cycle; at counter==0 go to VALID. Syn stays low for exactly GAP_CYCLES cycles.
  - VALID: syn=1, and entropy_data is stable until ack.
  - VALID, ack=1: word accepted. stats increments (saturating at 0xFFFFFFFF), gen advances, then go to GAP (counter=GAP_CYCLES-1), or stay in VALID if GAP_CYCLES=0.
  - In the GAP_CYCLES=0 case, back-to-back words are possible: the next word is presented the cycle after ack.
- Latency: enable sampled high at edge t -> enabled=1 after edge t; entropy_syn=1 after edge t+GAP_CYCLES.
- enable=0 sampled in any state: go to IDLE at the next edge; syn and enabled drop.
  - gen, stats and the gap counter's next use are unaffected; gen is retained and not reseeded.
  - Re-enable restarts with a full gap.
- Simultaneous ack and enable=0 while in VALID: the word is accepted (stats increments, gen advances), then go to IDLE.
- Ack while not in VALID is ignored: no count, no advance.
- No internal re-randomisation; the sequence is fully determined by SEED and the number of accepted words.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n low 2 cycles, enable=0 for 10 cycles.
  - Required: all outputs 0, stats=0, no syn.
- LFSR sequence:
  - Stimulus: MODE 2, SEED 1, GAP 0, enable=1, ack held high.
  - Required: entropy_data = 0x00000001, 0x00000003, 0x00000006, 0x0000000D on consecutive cycles; stats=4 afterwards.
- Counter with gap:
  - Stimulus: MODE 1, SEED 0xF1E2D3C4, GAP 3, single-cycle ack whenever syn.
  - Required: words 0xF1E2D3C4, 0xF1E2D3C5, 0xF1E2D3C6; syn low exactly 3 cycles between words and 3 cycles after enable.
- Backpressure:
  - Stimulus: MODE 2, withhold ack for 20 cycles.
  - Required: syn stays 1, data constant, stats unchanged; one ack -> stats+1.
- Disable with ack:
  - Stimulus: enable=0 and ack=1 in the same VALID cycle, then re-enable.
  - Required: stats+1, idle the next cycle; after re-enable the next word is the successor value (no reseed).
- Narrow width and corner cases:
  - Stimulus: DATA_WIDTH 8, MODE 0, SEED 0x000000A5.
  - Required: data 0xA5 on every word.
  - Stimulus: MODE 2, SEED 0.
  - Required: first word 0x01.
  - Stimulus: reset_n low mid-VALID.
  - Required: outputs 0, gen back to SEED.
